// File: rtl/eager_fork_dataflow_pkg.sv
// Shared constants for the eager fork: the value each per-branch pending flag
// takes on reset and after a token has been fully consumed.
package eager_fork_dataflow_pkg;

    localparam logic PENDING_RESET = 1'b1;

endpackage

// File: rtl/eager_fork_register_block.sv
// One branch of the eager fork: remembers whether this branch still owes the
// current token a transfer, and derives its valid and stall from that.
module eager_fork_register_block
    import eager_fork_dataflow_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic ins_ready,
    output logic outs_valid,
    output logic stall
);

    logic pending_q;
    logic pending_d;

    // A full consume re-arms the branch; a partial one clears it only if it transferred.
    always_comb begin
        pending_d = pending_q;
        if (ins_valid) begin
            if (ins_ready) begin
                pending_d = PENDING_RESET;
            end else begin
                pending_d = pending_q & ~outs_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= PENDING_RESET;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign outs_valid = ins_valid & pending_q;
    assign stall      = pending_q & ~outs_ready;

endmodule

// File: rtl/eager_fork_dataflow.sv
// Elastic eager fork: offers one input token to every output branch and
// consumes it once all branches have taken it, each at its own pace.
module eager_fork_dataflow #(
    parameter int OUTPUTS   = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_TYPE-1:0]           ins,
    input  logic                           ins_valid,
    output logic                           ins_ready,
    output logic [OUTPUTS*DATA_TYPE-1:0]   outs,
    output logic [OUTPUTS-1:0]             outs_valid,
    input  logic [OUTPUTS-1:0]             outs_ready
);

    logic [OUTPUTS-1:0] stall;

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_branch
        eager_fork_register_block u_reg (
            .clk        (clk),
            .rst        (rst),
            .ins_valid  (ins_valid),
            .outs_ready (outs_ready[i]),
            .ins_ready  (ins_ready),
            .outs_valid (outs_valid[i]),
            .stall      (stall[i])
        );

        assign outs[i*DATA_TYPE +: DATA_TYPE] = ins;
    end

    // The input can only retire when no still-owed branch is holding back.
    assign ins_ready = ~|stall;

endmodule

// File: tb/tb_eager_fork_dataflow.sv
// Bench for the eager fork: a three-way 8-bit instance checked against a
// per-branch transfer-count model, plus a one-way instance that must act as a wire.
module tb_eager_fork_dataflow;

    logic        clk;
    logic        rst;
    logic [7:0]  ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [23:0] outs;
    logic [2:0]  outs_valid;
    logic [2:0]  outs_ready;

    logic [7:0]  p1_ins;
    logic        p1_ins_valid;
    logic        p1_ins_ready;
    logic [7:0]  p1_outs;
    logic [0:0]  p1_outs_valid;
    logic [0:0]  p1_outs_ready;

    int vectors;
    int miscompares;

    int   cur_cnt [3];
    int   hits [3][256];
    int   dut_hs;
    bit   primed;
    logic [2:0] exp_valid;
    logic       exp_ready;

    eager_fork_dataflow #(.OUTPUTS(3), .DATA_TYPE(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    eager_fork_dataflow #(.OUTPUTS(1), .DATA_TYPE(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ins        (p1_ins),
        .ins_valid  (p1_ins_valid),
        .ins_ready  (p1_ins_ready),
        .outs       (p1_outs),
        .outs_valid (p1_outs_valid),
        .outs_ready (p1_outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic [2:0] rdy);
        @(posedge clk);
        #1;
        rst        = r;
        ins_valid  = v;
        ins        = d;
        outs_ready = rdy;
    endtask

    task automatic expectOut(input string name, input logic [2:0] ev, input logic er);
        #1;
        checkOutput({name, "_valid"}, 32'(outs_valid), 32'(ev));
        checkOutput({name, "_ready"}, 32'(ins_ready), 32'(er));
    endtask

    // Model: a branch is offered the token until it has transferred it once;
    // the input retires when every branch has either transferred or is ready now.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) exp_valid[i] = ins_valid && (cur_cnt[i] == 0);
        exp_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            if (cur_cnt[i] == 0 && !outs_ready[i]) exp_ready = 1'b0;

        if (primed) begin
            checkOutput("cyc_outs_valid", 32'(outs_valid), 32'(exp_valid));
            checkOutput("cyc_ins_ready", 32'(ins_ready), 32'(exp_ready));
            checkOutput("cyc_outs", 32'(outs), 32'({3{ins}}));
            checkOutput("w1_ins_ready", 32'(p1_ins_ready), 32'(p1_outs_ready[0]));
            checkOutput("w1_outs_valid", 32'(p1_outs_valid[0]), 32'(p1_ins_valid));
            checkOutput("w1_outs", 32'(p1_outs), 32'(p1_ins));
        end

        if (rst) begin
            for (int i = 0; i < 3; i++) cur_cnt[i] = 0;
            primed = 1'b1;
        end else if (ins_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_valid[i] && outs_ready[i]) begin
                    cur_cnt[i]++;
                    hits[i][int'(ins)]++;
                end
            end
            if (exp_ready) begin
                for (int i = 0; i < 3; i++) cur_cnt[i] = 0;
            end
        end

        if (!rst && ins_valid === 1'b1 && ins_ready === 1'b1) dut_hs++;
    end

    initial begin
        rst           = 1'b1;
        ins_valid     = 1'b0;
        ins           = 8'h00;
        outs_ready    = 3'b111;
        p1_ins        = 8'h00;
        p1_ins_valid  = 1'b0;
        p1_outs_ready = 1'b0;

        applyStimulus(1'b1, 1'b0, 8'h00, 3'b111);
        applyStimulus(1'b1, 1'b0, 8'h00, 3'b111);

        applyStimulus(1'b0, 1'b0, 8'h00, 3'b111);
        expectOut("reset_idle", 3'b000, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h11, 3'b111);
        expectOut("stream_11", 3'b111, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h22, 3'b111);
        expectOut("stream_22", 3'b111, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h33, 3'b111);
        expectOut("stream_33", 3'b111, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'hA5, 3'b001);
        expectOut("stag_c0", 3'b111, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA5, 3'b100);
        expectOut("stag_c1", 3'b110, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA5, 3'b010);
        expectOut("stag_c2", 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h5A, 3'b111);
        expectOut("stag_c3", 3'b111, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'hA5, 3'b001);
        expectOut("nodup_first", 3'b111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 8'hA5, 3'b001);
            expectOut("nodup_stall", 3'b110, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'hA5, 3'b111);
        expectOut("nodup_done", 3'b110, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h3C, 3'b010);
        expectOut("midrst_part", 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h3C, 3'b111);
        expectOut("midrst_rst", 3'b000, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h3C, 3'b000);
        expectOut("midrst_reoffer", 3'b111, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 3'b111);
        expectOut("midrst_done", 3'b111, 1'b1);

        applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);
        applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);
        #2;

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("hits_b%0d_11", i), 32'(hits[i][8'h11]), 32'd1);
            checkOutput($sformatf("hits_b%0d_22", i), 32'(hits[i][8'h22]), 32'd1);
            checkOutput($sformatf("hits_b%0d_33", i), 32'(hits[i][8'h33]), 32'd1);
            checkOutput($sformatf("hits_b%0d_A5", i), 32'(hits[i][8'hA5]), 32'd2);
            checkOutput($sformatf("hits_b%0d_5A", i), 32'(hits[i][8'h5A]), 32'd1);
            checkOutput($sformatf("hits_b%0d_3C", i), 32'(hits[i][8'h3C]), (i == 1) ? 32'd2 : 32'd1);
        end
        checkOutput("ins_handshakes", 32'(dut_hs), 32'd7);

        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            p1_ins           = 8'($urandom);
            p1_ins_valid     = 1'($urandom_range(0, 1));
            p1_outs_ready[0] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #6;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
